// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and transmitter state encoding
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS          = 8;
    localparam logic START_LEVEL        = 1'b0;
    localparam logic STOP_LEVEL         = 1'b1;
    localparam int   OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty and head-of-queue output
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // Writes against a full FIFO and reads of an empty one are ignored.
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle; a simultaneous push and pop cancels out.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and the registered flags derived from the next count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with optional parity
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow,
    output logic       uart_tx
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    tx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_pop;
    logic                 bit_end;
    logic                 line_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (reset),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // A bit period ends on the tick that completes OVERSAMPLE ticks.
    assign bit_end = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    // Pop when idle, or at the end of a stop bit so frames run back-to-back.
    assign fifo_pop = !tx_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    // Line level implied by the current state; registered into uart_tx below.
    always_comb begin
        line_level = STOP_LEVEL;
        case (state)
            ST_START:  line_level = START_LEVEL;
            ST_DATA:   line_level = shift[0];
            ST_PARITY: line_level = parity_bit;
            default:   line_level = STOP_LEVEL;
        endcase
    end

    // Sticky flag for writes dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_overflow <= 1'b0;
        end else if (tx_wr && tx_full) begin
            tx_overflow <= 1'b1;
        end
    end

    // Frame sequencer: tick counting, bit stepping, shift register and line output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            uart_tx    <= STOP_LEVEL;
        end else begin
            tx_done <= 1'b0;
            uart_tx <= line_level;
            if (state == ST_IDLE) begin
                if (!tx_empty) begin
                    shift      <= fifo_head;
                    parity_bit <= (^fifo_head) ^ (PARITY_ODD != 0);
                    tick_cnt   <= '0;
                    state      <= ST_START;
                    tx_busy    <= 1'b1;
                end
            end else if (baud_tick) begin
                if (bit_end) begin
                    tick_cnt <= '0;
                    case (state)
                        ST_START: begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                        ST_DATA: begin
                            shift <= shift >> 1;
                            if (bit_cnt == 3'(DATA_BITS - 1)) begin
                                state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            state <= ST_STOP;
                        end
                        ST_STOP: begin
                            tx_done <= 1'b1;
                            if (!tx_empty) begin
                                shift      <= fifo_head;
                                parity_bit <= (^fifo_head) ^ (PARITY_ODD != 0);
                                state      <= ST_START;
                            end else begin
                                state   <= ST_IDLE;
                                tx_busy <= 1'b0;
                            end
                        end
                        default: begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end
                    endcase
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

endmodule
